clint: RTL and testbench

Core-local interruptor: the source end of the machine-mode interrupt lines consumed by the CSR unit. Holds the memory-mapped `msip`, 64-bit `mtime` and 64-bit `mtimecmp` registers on a single-outstanding request/response bus, and drives `software_int_out` and `timer_int_out` into the CSR's `software_int_in` / `timer_int_in`. Single hart.

---
 rtl/clint_pkg.sv | 48 ++++
 rtl/clint_timer.sv | 39 +++
 rtl/clint.sv | 133 +++++++++++++
 tb/tb_clint.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/clint_pkg.sv
// Shared address map, bus FSM states and helpers for the core-local interruptor.
package clint_pkg;

  localparam logic [31:0] CLINT_MSIP        = 32'h0000_0000;
  localparam logic [31:0] CLINT_MTIMECMP_LO = 32'h0000_4000;
  localparam logic [31:0] CLINT_MTIMECMP_HI = 32'h0000_4004;
  localparam logic [31:0] CLINT_MTIME_LO    = 32'h0000_BFF8;
  localparam logic [31:0] CLINT_MTIME_HI    = 32'h0000_BFFC;

  typedef enum logic {S_IDLE, S_RESP} bus_state_e;

  typedef enum logic [2:0] {
    SEL_MSIP, SEL_CMP_LO, SEL_CMP_HI, SEL_TIME_LO, SEL_TIME_HI, SEL_NONE
  } reg_sel_e;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  // Misaligned addresses never match a register, so they fall into SEL_NONE.
  function automatic reg_sel_e decode(input logic [31:0] addr);
    reg_sel_e sel;
    sel = SEL_NONE;
    if (addr[1:0] == 2'b00) begin
      case (addr)
        CLINT_MSIP:        sel = SEL_MSIP;
        CLINT_MTIMECMP_LO: sel = SEL_CMP_LO;
        CLINT_MTIMECMP_HI: sel = SEL_CMP_HI;
        CLINT_MTIME_LO:    sel = SEL_TIME_LO;
        CLINT_MTIME_HI:    sel = SEL_TIME_HI;
        default:           sel = SEL_NONE;
      endcase
    end
    return sel;
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wstrb);
    logic [31:0] res;
    res = old;
    for (int b = 0; b < 4; b++)
      if (wstrb[b]) res[b*8 +: 8] = wdata[b*8 +: 8];
    return res;
  endfunction

endpackage

// File: rtl/clint_timer.sv
// Free-running 64-bit mtime with a TICK_DIV prescaler; a half-word write
// wins over the tick and suppresses that cycle's increment.
module clint_timer
  import clint_pkg::*;
#(
  parameter int TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] mtime,
  output logic        tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] presc;

  assign tick = (presc == PW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) presc <= '0;
    else        presc <= tick ? '0 : presc + PW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mtime <= '0;
    end else if (wr_en) begin
      if (wr_hi) mtime[63:32] <= wdata;
      else       mtime[31:0]  <= wdata;
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

endmodule

// File: rtl/clint.sv
// Core-local interruptor: msip / mtimecmp / mtime behind a single-outstanding
// request/response port, driving the machine software and timer interrupts.
module clint
  import clint_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int TICK_DIV = 1,
  parameter int ADDR_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [3:0]        req_wstrb,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_err,
  output logic              software_int_out,
  output logic              timer_int_out
);

  bus_state_e  state, state_nx;
  reg_sel_e    sel;
  resp_t       resp_q;
  logic        acc, err, wr;
  logic        msip;
  logic [63:0] mtimecmp, mtime;
  logic        tick, timer_q;
  logic        time_wr;
  logic [31:0] wdata32, rd_mux, time_wdata;

  assign wdata32 = 32'(req_wdata);
  assign sel     = decode(32'(req_addr));
  assign err     = (sel == SEL_NONE);
  assign acc     = req_valid && (state == S_IDLE);
  assign wr      = acc && req_we && !err;

  // FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  // FSM: next state
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (req_valid)  state_nx = S_RESP;
      S_RESP:  if (resp_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      S_IDLE:  req_ready  = 1'b1;
      S_RESP:  resp_valid = 1'b1;
      default: req_ready  = 1'b0;
    endcase
  end

  // Read data is taken from register state ahead of the accept edge.
  always_comb begin
    rd_mux = '0;
    case (sel)
      SEL_MSIP:    rd_mux = {31'b0, msip};
      SEL_CMP_LO:  rd_mux = mtimecmp[31:0];
      SEL_CMP_HI:  rd_mux = mtimecmp[63:32];
      SEL_TIME_LO: rd_mux = mtime[31:0];
      SEL_TIME_HI: rd_mux = mtime[63:32];
      default:     rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_q <= '0;
    end else if (acc) begin
      resp_q.rdata <= (req_we || err) ? 32'b0 : rd_mux;
      resp_q.err   <= err;
    end
  end

  assign resp_rdata = XLEN'(resp_q.rdata);
  assign resp_err   = resp_q.err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      msip     <= 1'b0;
      mtimecmp <= '1;
    end else if (wr) begin
      case (sel)
        SEL_MSIP:   if (req_wstrb[0]) msip <= wdata32[0];
        SEL_CMP_LO: mtimecmp[31:0]  <= merge_bytes(mtimecmp[31:0],  wdata32, req_wstrb);
        SEL_CMP_HI: mtimecmp[63:32] <= merge_bytes(mtimecmp[63:32], wdata32, req_wstrb);
        default: ;
      endcase
    end
  end

  // An all-zero strobe is a true no-op: it must not stall the tick either.
  assign time_wr    = wr && (req_wstrb != 4'b0) &&
                      ((sel == SEL_TIME_LO) || (sel == SEL_TIME_HI));
  assign time_wdata = merge_bytes((sel == SEL_TIME_HI) ? mtime[63:32] : mtime[31:0],
                                  wdata32, req_wstrb);

  clint_timer #(.TICK_DIV(TICK_DIV)) u_timer (
    .clk   (clk),
    .reset (reset),
    .wr_en (time_wr),
    .wr_hi (sel == SEL_TIME_HI),
    .wdata (time_wdata),
    .mtime (mtime),
    .tick  (tick)
  );

  // Compare runs on the registered values, so the interrupt trails the update by one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) timer_q <= 1'b0;
    else        timer_q <= (mtime >= mtimecmp);
  end

  assign software_int_out = msip;
  assign timer_int_out    = timer_q;

endmodule

// File: tb/tb_clint.sv
// Randomized and directed checks of clint against a cycle-level reference model.
module tb_clint;

  localparam int TICK_DIV = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0, resp_ready = 1'b1;
  logic [15:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        req_ready, resp_valid, resp_err, software_int_out, timer_int_out;
  logic [31:0] resp_rdata;

  always #5 clk = ~clk;

  clint #(.XLEN(32), .TICK_DIV(TICK_DIV), .ADDR_W(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .software_int_out(software_int_out), .timer_int_out(timer_int_out)
  );

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model state
  logic [63:0] m_time, m_cmp;
  logic        m_msip, m_tint, m_rv, m_err;
  logic [31:0] m_rdata;
  int unsigned cyc;

  function automatic int m_decode(input logic [15:0] a);
    if (a[1:0] != 2'b00) return -1;
    if (a == 16'h0000) return 0;
    if (a == 16'h4000) return 1;
    if (a == 16'h4004) return 2;
    if (a == 16'hBFF8) return 3;
    if (a == 16'hBFFC) return 4;
    return -1;
  endfunction

  function automatic logic [31:0] put_bytes(input logic [31:0] old, input logic [31:0] d,
                                            input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  task automatic m_reset();
    m_time = 64'd0; m_cmp = '1; m_msip = 0; m_tint = 0;
    m_rv = 0; m_err = 0; m_rdata = 0; cyc = 0;
  endtask

  task automatic check_all();
    chk("req_ready", req_ready, !m_rv);
    chk("resp_valid", resp_valid, m_rv);
    chk("software_int", software_int_out, m_msip);
    chk("timer_int", timer_int_out, m_tint);
    if (m_rv) begin
      chk("resp_rdata", resp_rdata, m_rdata);
      chk("resp_err", resp_err, m_err);
    end
  endtask

  // Advance model and DUT by one clock using the inputs currently driven.
  task automatic step();
    logic [63:0] t, c;
    logic ms, ti, rv, er, twr;
    logic [31:0] rd;
    int r;
    t = m_time; c = m_cmp; ms = m_msip; rv = m_rv; rd = m_rdata; er = m_err; twr = 0;
    ti = (m_time >= m_cmp);
    if (m_rv && resp_ready) rv = 0;
    if (req_valid && !m_rv) begin
      r = m_decode(req_addr);
      rv = 1; er = (r < 0); rd = 0;
      if (!req_we) begin
        case (r)
          0: rd = {31'b0, m_msip};
          1: rd = m_cmp[31:0];
          2: rd = m_cmp[63:32];
          3: rd = m_time[31:0];
          4: rd = m_time[63:32];
          default: rd = 0;
        endcase
      end else begin
        case (r)
          0: if (req_wstrb[0]) ms = req_wdata[0];
          1: c[31:0] = put_bytes(m_cmp[31:0], req_wdata, req_wstrb);
          2: c[63:32] = put_bytes(m_cmp[63:32], req_wdata, req_wstrb);
          3: begin t[31:0] = put_bytes(m_time[31:0], req_wdata, req_wstrb); twr = (req_wstrb != 0); end
          4: begin t[63:32] = put_bytes(m_time[63:32], req_wdata, req_wstrb); twr = (req_wstrb != 0); end
          default: ;
        endcase
      end
    end
    if (!twr && (cyc % TICK_DIV) == TICK_DIV - 1) t = m_time + 64'd1;
    @(posedge clk); #1;
    m_time = t; m_cmp = c; m_msip = ms; m_tint = ti; m_rv = rv; m_rdata = rd; m_err = er;
    cyc++;
    check_all();
  endtask

  task automatic xact(input logic we, input logic [15:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rd, output logic e);
    req_valid = 1; req_we = we; req_addr = a; req_wdata = d; req_wstrb = s;
    step();
    rd = resp_rdata; e = resp_err;
    req_valid = 0;
    step();
  endtask

  task automatic do_reset();
    reset = 0; #1;
    m_reset();
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_err", resp_err, 1'b0);
    chk("rst_swi", software_int_out, 1'b0);
    chk("rst_tint", timer_int_out, 1'b0);
  endtask

  initial begin
    logic [31:0] rd;
    logic e;
    bit hit;
    #2;
    do_reset();
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1;

    // mtime advances once every TICK_DIV cycles from reset release
    repeat (10) step();
    xact(0, 16'hBFF8, 0, 0, rd, e);
    chk("mtime_lo_after_10", rd, 32'd2);

    // msip: only bit 0 is stored
    xact(1, 16'h0000, 32'h1, 4'hF, rd, e);
    xact(1, 16'h0000, 32'hFFFF_FFFE, 4'hF, rd, e);
    xact(0, 16'h0000, 0, 0, rd, e);
    chk("msip_read", rd, 32'h0);

    // timer interrupt rise and fall
    xact(1, 16'h4004, 32'h0, 4'hF, rd, e);
    xact(1, 16'h4000, 32'd100, 4'hF, rd, e);
    hit = 0;
    for (int i = 0; i < 600 && !hit; i++) begin
      step();
      hit = timer_int_out;
    end
    chk("timer_rise_seen", hit, 1'b1);
    chk("mtime_at_rise", m_time >= 64'd100, 1'b1);
    xact(1, 16'h4000, 32'hFFFF_FFFF, 4'hF, rd, e);
    chk("timer_fall", timer_int_out, 1'b0);

    // carry from lo into hi
    xact(1, 16'hBFFC, 32'h0, 4'hF, rd, e);
    xact(1, 16'hBFF8, 32'hFFFF_FFFF, 4'hF, rd, e);
    repeat (8) step();
    xact(0, 16'hBFFC, 0, 0, rd, e);
    chk("mtime_hi_carry", rd, 32'h1);

    // write landing on a tick cycle holds the written value
    for (int i = 0; i < 8 && (cyc % TICK_DIV) != TICK_DIV - 1; i++) step();
    xact(1, 16'hBFF8, 32'h0000_1234, 4'hF, rd, e);
    chk("tick_write_held", m_time[31:0], 32'h0000_1234);
    xact(0, 16'hBFF8, 0, 0, rd, e);
    chk("tick_write_read", rd, 32'h0000_1234);

    // unmapped / misaligned / no-op strobe
    xact(0, 16'h0010, 0, 0, rd, e);
    chk("unmapped_err", e, 1'b1);
    chk("unmapped_rdata", rd, 32'h0);
    xact(0, 16'h4002, 0, 0, rd, e);
    chk("misaligned_err", e, 1'b1);
    xact(1, 16'h0010, 32'hDEAD_BEEF, 4'hF, rd, e);
    xact(1, 16'h4000, 32'h1234_5678, 4'h0, rd, e);
    chk("nostrobe_err", e, 1'b0);
    xact(0, 16'h4000, 0, 0, rd, e);
    chk("nostrobe_cmp", rd, 32'hFFFF_FFFF);

    // stalled response, then reset mid-stall
    resp_ready = 0;
    req_valid = 1; req_we = 0; req_addr = 16'h4004;
    step();
    req_valid = 0;
    repeat (5) step();
    chk("stall_valid", resp_valid, 1'b1);
    #2;
    do_reset();
    @(negedge clk) reset = 1;
    resp_ready = 1;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      req_valid  = $urandom_range(0, 1);
      req_we     = $urandom_range(0, 1);
      req_wdata  = $urandom;
      req_wstrb  = 4'($urandom_range(0, 15));
      resp_ready = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 8))
        0: req_addr = 16'h0000;
        1: req_addr = 16'h4000;
        2: begin req_addr = 16'h4004; req_wdata = $urandom_range(0, 1); end
        3: req_addr = 16'hBFF8;
        4: begin req_addr = 16'hBFFC; req_wdata = $urandom_range(0, 1); end
        5: req_addr = 16'h0010;
        6: req_addr = 16'h4002;
        7: req_addr = 16'hBFF8;
        default: req_addr = 16'($urandom);
      endcase
      step();
    end
    req_valid = 0; resp_ready = 1;
    repeat (2) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
